fb_read_scheduler: RTL and testbench
====================================

# fb_read_scheduler

Frame-buffer access scheduler between the edge-detection write stream and the VGA display. It shares one single-port frame-buffer RAM between two users:
- a display prefetcher, which keeps a small pixel FIFO ahead of the raster;
- a writer (the edge-detect pipeline) with a valid/ready handshake.

Display reads have absolute priority. Writes are granted only in slots the prefetcher does not need, which in practice means blanking intervals. The block sits between the VGA timing generator and the frame-buffer RAM, in the `vgaClk` domain.

## Interface
- `HACTIVE`, 640, active pixels per line
- `VACTIVE`, 480, active lines per frame
- `AW`, 19, frame-buffer address width (must satisfy 2^AW ≥ HACTIVE*VACTIVE)
- `DW`, 8, pixel/word width
- `FDEPTH`, 4, prefetch FIFO depth (minimum 4)
- `vgaClk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `frameStart`  in  1  one-cycle pulse in vertical blanking: flush and restart display fetch at address 0
- `pixReq`  in  1  display consumes one pixel; asserted one cycle before the pixel is shown
- `pixData`  out  DW  pixel returned for the previous cycle's `pixReq`
- `pixValid`  out  1  `pixData` holds a fetched pixel
- `underflow`  out  1  sticky; set on `pixReq` with an empty FIFO
- `wrValid`  in  1  writer has a word
- `wrReady`  out  1  write granted this cycle
- `wrAddr`  in  AW  write address
- `wrData`  in  DW  write data
- `memEn`  out  1  RAM access strobe (registered)
- `memWe`  out  1  RAM write enable (registered)
- `memAddr`  out  AW  RAM address (registered)
- `memWdata`  out  DW  RAM write data (registered)
- `memRdata`  in  DW  RAM read data, valid one cycle after `memEn` with `!memWe`

## Operation
- **States:** IDLE (reset), FILL, RUN.
- **Transitions:**
  - IDLE→FILL on `frameStart`.
  - FILL→RUN when occupancy + inflight == `FDEPTH`.
  - RUN→FILL on `frameStart`.
  - `frameStart` in FILL restarts FILL.
- **Counters:**
  - `rdAddr` (AW): next display address.
  - `occ`: FIFO entries.
  - `inflight`: issued reads not yet returned, 0..2.
- **Read issue:** in FILL/RUN when `occ + inflight < FDEPTH` (both registered values).
  - Drives `memEn`=1, `memWe`=0, `memAddr`=`rdAddr` on the next edge.
  - `rdAddr` increments and wraps from HACTIVE*VACTIVE−1 to 0.
- **Write grant:** `wrReady` = 1 in any cycle where no read issues (IDLE included).
  - `wrReady` must not depend combinationally on `wrValid`.
  - On `wrValid && wrReady`, the next edge drives `memEn`=1, `memWe`=1, `memAddr`=`wrAddr`, `memWdata`=`wrData`.
  - With no grant used, `memEn`=0 and `memWe`=0.
- **Read return:** pushed into the FIFO two cycles after the issue decision, i.e. one cycle after `memEn`.
- **frameStart:**
  - FIFO emptied and `rdAddr`=0.
  - Reads already in flight are counted down and their data discarded, never pushed.
  - A write granted in the same cycle still completes.
- **pixReq, FIFO non-empty:** the FIFO pops, and next cycle `pixValid`=1 with `pixData`=head.
- **pixReq, FIFO empty:** next cycle `pixValid`=0 and `pixData`=0, and `underflow` sets. `underflow` is cleared only by `rst`.
- **No pixReq:** `pixValid`=0 next cycle and `pixData` holds its value.
- **Push and pop in the same cycle:** allowed; `occ` is unchanged.
- **Write collisions:** overwriting a pixel already prefetched is not detected; the stale value is displayed.

## Timing
- **Reset values:**
  - all outputs 0 (`wrReady` included, reflecting IDLE);
  - `rdAddr`=0, `occ`=0, `inflight`=0, state IDLE.
  - Reset mid-frame is immediate and loses FIFO contents.
- **Latencies:**
  - write acceptance → RAM write: 1 cycle;
  - read issue → FIFO entry: 2 cycles;
  - `pixReq` → `pixData`: 1 cycle.
- **Fill time:** `frameStart` → RUN takes `FDEPTH`+2 cycles with no `pixReq`.
- **Throughput:**
  - one read per cycle is sustained under continuous `pixReq` (`occ + inflight` settles at `FDEPTH`−1);
  - the writer therefore receives no slots during active video;
  - after `pixReq` stops, `wrReady` rises within 3 cycles.

## Configuration
- **Macro:** `FB_UNDERFLOW_REPEAT_EN`.
- **Defined:** on underflow, `pixData` repeats the last valid pixel and `pixValid`=0.
- **Undefined:** `pixData`=0 on underflow.
- `underflow` flag behaviour is identical in both cases.

## Test plan
- **Reset:** assert `rst` mid-RUN → all outputs 0 immediately; `wrReady`=1 the first cycle after release in IDLE.
- **Write then display:** write 0x11/0x22/0x33/0x44 to addresses 0–3 in IDLE, pulse `frameStart`, wait 6 cycles, `pixReq` ×4 → `pixValid`=1 and `pixData` 0x11, 0x22, 0x33, 0x44, one cycle after each request.
- **Priority:** hold `pixReq` 100 cycles in RUN with `wrValid`=1 → `wrReady`=0 throughout, no underflow; drop `pixReq` → `wrReady`=1 within 3 cycles.
- **Underflow:** `frameStart`, `pixReq` next cycle → `pixValid`=0, `pixData`=0x00 (last pixel with macro), `underflow`=1 and held until `rst`.
- **Wrap:** run to `rdAddr`=307199 → next issued `memAddr`=0.
- **Mid-fill restart:** `frameStart` while 2 reads are in flight → those returns are discarded; the first subsequent `pixData` comes from address 0.

Source files
------------

// File: rtl/fb_read_scheduler.sv
// rtl/fb_read_scheduler.sv - shares one frame-buffer RAM between display prefetch (priority) and a writer
// Optional: FB_UNDERFLOW_REPEAT_EN holds the last valid pixel on underflow instead of driving 0.
module fb_read_scheduler #(
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int AW      = 19,
  parameter int DW      = 8,
  parameter int FDEPTH  = 4
) (
  input  logic          vgaClk,
  input  logic          rst,
  input  logic          frameStart,
  input  logic          pixReq,
  output logic [DW-1:0] pixData,
  output logic          pixValid,
  output logic          underflow,
  input  logic          wrValid,
  output logic          wrReady,
  input  logic [AW-1:0] wrAddr,
  input  logic [DW-1:0] wrData,
  output logic          memEn,
  output logic          memWe,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memWdata,
  input  logic [DW-1:0] memRdata
);
  localparam int NPIX = HACTIVE * VACTIVE;
  localparam int PW   = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW   = $clog2(FDEPTH + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state_q, state_d;

  logic [AW-1:0] rd_addr_q;
  logic [CW-1:0] occ_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [DW-1:0] fifo_q [FDEPTH];
  logic          rd_s1_q, rd_s2_q, keep2_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, pix_data_q;
  logic          pix_valid_q, underflow_q;

  logic [1:0]    inflight;
  logic [CW:0]   level;
  logic          rd_issue, wr_go, push, pop;

  // Reads are in flight from the issue edge until their data is pushed two stages later.
  assign inflight = {1'b0, rd_s1_q} + {1'b0, rd_s2_q};
  assign level    = (CW+1)'(occ_q) + (CW+1)'(inflight);
  assign push     = keep2_q & ~frameStart;
  assign pop      = pixReq & (occ_q != '0);

  always_ff @(posedge vgaClk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frameStart) state_d = FILL;
      FILL:    if (frameStart) state_d = FILL;
               else if (level == (CW+1)'(FDEPTH)) state_d = RUN;
      RUN:     if (frameStart) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_issue = (state_q != IDLE) && !frameStart && (level < (CW+1)'(FDEPTH));
    wrReady  = !rst && !rd_issue;
    wr_go    = wrValid && !rd_issue;
  end

  always_ff @(posedge vgaClk or posedge rst) begin
    if (rst) begin
      rd_addr_q   <= '0;
      occ_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_s1_q     <= 1'b0;
      rd_s2_q     <= 1'b0;
      keep2_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_en_q <= rd_issue | wr_go;
      mem_we_q <= wr_go;
      if (rd_issue)   mem_addr_q <= rd_addr_q;
      else if (wr_go) mem_addr_q <= wrAddr;
      if (wr_go) mem_wdata_q <= wrData;

      // A frame restart lets in-flight reads drain but drops their data.
      rd_s1_q <= rd_issue;
      rd_s2_q <= rd_s1_q;
      keep2_q <= rd_s1_q & ~frameStart;

      if (frameStart) begin
        rd_addr_q <= '0;
        occ_q     <= '0;
        wptr_q    <= '0;
        rptr_q    <= '0;
      end else begin
        if (rd_issue)
          rd_addr_q <= (rd_addr_q == AW'(NPIX - 1)) ? '0 : rd_addr_q + AW'(1);
        if (push)
          wptr_q <= (wptr_q == PW'(FDEPTH - 1)) ? '0 : wptr_q + PW'(1);
        if (pop)
          rptr_q <= (rptr_q == PW'(FDEPTH - 1)) ? '0 : rptr_q + PW'(1);
        occ_q <= occ_q + CW'(push) - CW'(pop);
      end

      if (pop) begin
        pix_valid_q <= 1'b1;
        pix_data_q  <= fifo_q[rptr_q];
      end else if (pixReq) begin
        pix_valid_q <= 1'b0;
        underflow_q <= 1'b1;
`ifdef FB_UNDERFLOW_REPEAT_EN
        pix_data_q  <= pix_data_q;
`else
        pix_data_q  <= '0;
`endif
      end else begin
        pix_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge vgaClk) begin
    if (push) fifo_q[wptr_q] <= memRdata;
  end

  assign memEn     = mem_en_q;
  assign memWe     = mem_we_q;
  assign memAddr   = mem_addr_q;
  assign memWdata  = mem_wdata_q;
  assign pixData   = pix_data_q;
  assign pixValid  = pix_valid_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_fb_read_scheduler.sv
// tb/tb_fb_read_scheduler.sv - self-checking bench for fb_read_scheduler with a queue-based display model
`timescale 1ns/1ps
module tb_fb_read_scheduler;
  localparam int HA = 8, VA = 4, AW = 19, DW = 8, FD = 4;
  localparam int NPIX = HA * VA;
  localparam int RSZ  = NPIX + 256;

  logic          clk = 1'b0, rst = 1'b1;
  logic          fs = 1'b0, pr = 1'b0, wv = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] pixData, memWdata, rdata = '0;
  logic          pixValid, underflow, wrReady, memEn, memWe;
  logic [AW-1:0] memAddr;

  fb_read_scheduler #(.HACTIVE(HA), .VACTIVE(VA), .AW(AW), .DW(DW), .FDEPTH(FD)) dut (
    .vgaClk(clk), .rst(rst), .frameStart(fs), .pixReq(pr),
    .pixData(pixData), .pixValid(pixValid), .underflow(underflow),
    .wrValid(wv), .wrReady(wrReady), .wrAddr(wa), .wrData(wd),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [RSZ];
  always @(posedge clk) begin
    if (memEn && int'(memAddr) < RSZ) begin
      if (memWe) ram[int'(memAddr)] <= memWdata;
      else       rdata <= ram[int'(memAddr)];
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: display FIFO and outstanding reads as queues; outputs follow from the rules directly.
  typedef struct { int due; int addr; bit keep; } fly_t;
  fly_t          fly[$];
  logic [DW-1:0] mfifo[$];
  bit            m_active = 0;
  int            m_rdaddr = 0, cyc = 0;
  logic [DW-1:0] m_last = '0, e_pdata = '0, e_wdata = '0;
  bit            e_pvalid = 0, e_uf = 0, e_en = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;

  function automatic bit m_issue(input bit fsv);
    return m_active && !fsv && (mfifo.size() + fly.size() < FD);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit iss, wrg;
    if (rst) begin
      fly.delete(); mfifo.delete();
      m_active = 0; m_rdaddr = 0; cyc = 0; m_last = '0;
      e_pdata = '0; e_pvalid = 0; e_uf = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    end else begin
      iss = m_issue(fs);
      wrg = wv && !iss;
      e_en = iss || wrg;
      e_we = wrg;
      if (iss) e_addr = AW'(m_rdaddr);
      else if (wrg) e_addr = wa;
      if (wrg) e_wdata = wd;
      if (pr && mfifo.size() > 0) begin
        e_pvalid = 1; e_pdata = mfifo.pop_front(); m_last = e_pdata;
      end else if (pr) begin
        e_pvalid = 0; e_uf = 1;
`ifdef FB_UNDERFLOW_REPEAT_EN
        e_pdata = m_last;
`else
        e_pdata = '0;
`endif
      end else begin
        e_pvalid = 0;
      end
      if (fly.size() > 0 && fly[0].due == cyc) begin
        if (fly[0].keep && !fs) mfifo.push_back(ram[fly[0].addr]);
        void'(fly.pop_front());
      end
      if (fs) begin
        mfifo.delete();
        foreach (fly[i]) fly[i].keep = 0;
        m_rdaddr = 0; m_active = 1;
      end
      if (iss) begin
        fly.push_back('{cyc + 2, m_rdaddr, 1'b1});
        m_rdaddr = (m_rdaddr + 1) % NPIX;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    chk("memEn", memEn, e_en);
    chk("memWe", memWe, e_we);
    if (e_en) chk("memAddr", memAddr, e_addr);
    if (e_en && e_we) chk("memWdata", memWdata, e_wdata);
    chk("pixValid", pixValid, e_pvalid);
    chk("pixData", pixData, e_pdata);
    chk("underflow", underflow, e_uf);
    chk("wrReady", wrReady, !rst && !m_issue(fs));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int prev;
    bit got;
    for (int a = 0; a < RSZ; a++) ram[a] = DW'(a * 13 + 7);

    repeat (3) step();
    chk("rst_memEn", memEn, 0);
    chk("rst_memWe", memWe, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWdata", memWdata, 0);
    chk("rst_pixData", pixData, 0);
    chk("rst_pixValid", pixValid, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_wrReady", wrReady, 0);
    rst = 1'b0; #1;
    chk("idle_wrReady", wrReady, 1);

    for (int i = 0; i < 4; i++) begin
      wv = 1'b1; wa = AW'(i); wd = DW'(8'h11 * (i + 1));
      step();
    end
    wv = 1'b0;
    step();
    fs = 1'b1; step(); fs = 1'b0;
    repeat (5) step();
    pr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) pr = 1'b0;
      #1;
      chk("wd_pixValid", pixValid, 1);
      chk("wd_pixData", pixData, DW'(8'h11 * (i + 1)));
    end

    repeat (6) step();
    wv = 1'b1; wa = AW'(NPIX + 5); wd = 8'hA5; pr = 1'b1;
    for (int k = 0; k < 99; k++) begin
      step(); #1;
      chk("prio_wrReady", wrReady, 0);
      chk("prio_underflow", underflow, 0);
    end
    step(); pr = 1'b0;
    got = 0;
    for (int j = 0; j < 3 && !got; j++) begin
      step(); #1;
      if (wrReady) got = 1;
    end
    chk("prio_wrReady_rise", got, 1);
    wv = 1'b0;

    step();
    fs = 1'b1; step(); fs = 1'b0;
    repeat (5) step();
    pr = 1'b1; prev = -1; got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      step(); #1;
      if (memEn && !memWe) begin
        if (prev == 31) begin
          chk("wrap_addr", memAddr, 0);
          got = 1;
        end
        prev = int'(memAddr);
      end
    end
    chk("wrap_seen", got, 1);
    pr = 1'b0;

    repeat (3) step();
    fs = 1'b1; step(); fs = 1'b0;
    step(); step();
    fs = 1'b1; step(); fs = 1'b0;
    repeat (5) step();
    pr = 1'b1; step(); pr = 1'b0; #1;
    chk("restart_pixValid", pixValid, 1);
    chk("restart_pixData", pixData, 8'h11);

    repeat (3) step();
    chk("pre_uf_underflow", underflow, 0);
    fs = 1'b1; step(); fs = 1'b0;
    pr = 1'b1; step(); pr = 1'b0; #1;
    chk("uf_pixValid", pixValid, 0);
`ifdef FB_UNDERFLOW_REPEAT_EN
    chk("uf_pixData", pixData, 8'h11);
`else
    chk("uf_pixData", pixData, 8'h00);
`endif
    chk("uf_flag", underflow, 1);
    repeat (5) step();
    chk("uf_sticky", underflow, 1);

    repeat (3) step();
    pr = 1'b1; step(); step(); #2;
    rst = 1'b1; #1;
    chk("midrst_memEn", memEn, 0);
    chk("midrst_pixValid", pixValid, 0);
    chk("midrst_pixData", pixData, 0);
    chk("midrst_underflow", underflow, 0);
    chk("midrst_wrReady", wrReady, 0);
    pr = 1'b0;
    step(); rst = 1'b0; #1;
    chk("post_rst_wrReady", wrReady, 1);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
